afifo_rd_packer: RTL

//  Read-side consumer of the async FIFO, in the rclk domain. Pops first-word-fall-through

---
 rtl/afifo_rd_packer.sv | 106 ++++++++++
 1 files changed

// File: rtl/afifo_rd_packer.sv
// afifo_rd_packer: pops FWFT FIFO words in the read domain and packs PACK of them per valid/ready beat
module afifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         rclk,
    input  logic                         rrst_n,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic                         rempty,
    output logic                         rinc,
    input  logic                         flush,
    output logic [DATA_WIDTH*PACK-1:0]   m_data,
    output logic [PACK-1:0]              m_keep,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         pop_cnt
);
    localparam int FW = $clog2(PACK + 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [FW-1:0]               fcnt;
    logic [DATA_WIDTH-1:0]       acc [PACK];
    logic [DATA_WIDTH*PACK-1:0]  acc_flat;
    logic [PACK:0]               keep_full;
    logic                        out_free;
    logic                        xfer;
    logic                        pop;

    // A beat moves to the output register when the slot is free and either the
    // accumulator is full or a drain has something to close.
    assign out_free = !m_valid || m_ready;
    assign xfer     = out_free && ((fcnt == FW'(PACK)) || (state == DRAIN && fcnt != '0));
    // Popping into a full accumulator is only allowed when it empties this same cycle;
    // reset gates the strobe so nothing is lost from the FIFO while held in reset.
    assign pop      = rrst_n && !rempty && state == FILL && (fcnt < FW'(PACK) || xfer);
    assign rinc     = pop;
    assign busy     = state == DRAIN || fcnt != '0 || m_valid;

    // Flatten the accumulator (word 0 in the LSBs) and build the keep mask for fcnt words.
    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < PACK; i++) acc_flat[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
        keep_full = ((PACK+1)'(1) << fcnt) - (PACK+1)'(1);
    end

    // Next state: flush opens a drain; a drain closes after its beat leaves or if empty.
    always_comb begin
        state_nxt = state;
        if (state == FILL) begin
            if (flush) state_nxt = DRAIN;
        end else if (fcnt == '0 || xfer) begin
            state_nxt = FILL;
        end
    end

    // State register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) state <= FILL;
        else         state <= state_nxt;
    end

    // Accumulator: a pop coinciding with a transfer starts the next beat at word 0.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            fcnt <= '0;
            for (int i = 0; i < PACK; i++) acc[i] <= '0;
        end else if (xfer) begin
            for (int i = 0; i < PACK; i++) acc[i] <= (pop && i == 0) ? rdata : '0;
            fcnt <= pop ? FW'(1) : '0;
        end else if (pop) begin
            for (int i = 0; i < PACK; i++) if (FW'(i) == fcnt) acc[i] <= rdata;
            fcnt <= fcnt + 1'b1;
        end
    end

    // Output register: loads on transfer, clears its flags on acceptance, holds while stalled.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (xfer) begin
            m_data  <= acc_flat;
            m_keep  <= keep_full[PACK-1:0];
            m_last  <= state == DRAIN;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_keep  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    // Free-running count of words popped, wrapping at 2^CNT_WIDTH.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)  pop_cnt <= '0;
        else if (pop) pop_cnt <= pop_cnt + 1'b1;
    end
endmodule
